// File: rtl/mem_dump_if.sv
// mem_dump_if: bundles the request, memory-read and character-stream signals
// of the hex-dump engine.
//   start/addr_i/len_i      : dump request (addr_i, len_i captured on start)
//   busy_o/done_o           : status
//   mem_a_o/mem_re_o/mem_d_i: byte memory read port (data one cycle after re)
//   ch_o/ch_v_o/ch_r_i      : valid/ready ASCII output stream
// The engine connects through the slave modport; the requester/memory/sink
// side uses the master modport.
interface mem_dump_if #(
  parameter int AW = 17
);
  logic          start;
  logic [AW-1:0] addr_i;
  logic [AW-1:0] len_i;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] mem_a_o;
  logic          mem_re_o;
  logic [7:0]    mem_d_i;
  logic [7:0]    ch_o;
  logic          ch_v_o;
  logic          ch_r_i;

  modport slave (
    input  start, addr_i, len_i, mem_d_i, ch_r_i,
    output busy_o, done_o, mem_a_o, mem_re_o, ch_o, ch_v_o
  );

  modport master (
    output start, addr_i, len_i, mem_d_i, ch_r_i,
    input  busy_o, done_o, mem_a_o, mem_re_o, ch_o, ch_v_o
  );
endinterface

// File: rtl/mem_dump.sv
// mem_dump: hardware hex-dump engine. Reads whole ROW-byte rows covering
// [addr_i, addr_i+len_i) into a local buffer, then streams each row as
// "\n<addr>: <hex groups>  <ascii>" followed by a final "\n".
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_dump_if slave (request, memory read port, character stream)
//
// state | meaning
// IDLE  | waiting for start
// FETCH | reading ROW bytes of the current row into the buffer
// NL    | emitting the leading newline of a row
// ADR   | emitting ADIG hex digits of the row base
// COLON | emitting ':'
// HEX   | emitting group space / high nibble / low nibble per byte
// SEP   | emitting two spaces
// ASC   | emitting the printable-character column
// FIN   | emitting the trailing newline of the dump
// DONE  | one-cycle completion pulse
module mem_dump #(
  parameter int AW   = 17,
  parameter int ROW  = 16,
  parameter int GRP  = 4,
  parameter int ADIG = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_dump_if.slave bus
);
  localparam int IW = $clog2(ROW);
  localparam int EW = ADIG * 4;
  localparam int CW = (AW < EW) ? AW : EW;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_NL    = 4'd2;
  localparam logic [3:0] S_ADR   = 4'd3;
  localparam logic [3:0] S_COLON = 4'd4;
  localparam logic [3:0] S_HEX   = 4'd5;
  localparam logic [3:0] S_SEP   = 4'd6;
  localparam logic [3:0] S_ASC   = 4'd7;
  localparam logic [3:0] S_FIN   = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  logic [3:0]    r_state;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_rows;
  logic [IW:0]   r_fcnt;
  logic          r_rd_v;
  logic [IW-1:0] r_rd_idx;
  logic [7:0]    r_idx;
  logic [1:0]    r_sub;
  logic [7:0]    r_buf [ROW];

  logic          w_xfer;
  logic          w_re;
  logic [AW:0]   w_span;
  logic [7:0]    w_byte;
  logic [EW-1:0] w_base_ext;
  logic [3:0]    w_nib;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign w_xfer     = bus.ch_v_o && bus.ch_r_i;
  assign w_re       = (r_state == S_FETCH) && (r_fcnt < (IW+1)'(ROW));
  // Rows needed = ceil((addr mod ROW + len) / ROW); one extra bit avoids overflow.
  assign w_span     = ({1'b0, bus.len_i} + (AW+1)'(bus.addr_i[IW-1:0])
                       + (AW+1)'(ROW-1)) >> IW;
  assign w_byte     = r_buf[r_idx[IW-1:0]];
  assign w_base_ext = EW'(r_base[CW-1:0]);

  always_comb begin
    w_nib = 4'h0;
    if (int'(r_idx) < ADIG)
      w_nib = 4'(w_base_ext >> (4 * (ADIG - 1 - int'(r_idx))));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_rows   <= '0;
      r_fcnt   <= '0;
      r_rd_v   <= 1'b0;
      r_rd_idx <= '0;
      r_idx    <= '0;
      r_sub    <= '0;
    end else begin
      r_rd_v   <= w_re;
      r_rd_idx <= r_fcnt[IW-1:0];
      case (r_state)
        S_IDLE: if (bus.start) begin
          if (bus.len_i != '0) begin
            r_base  <= bus.addr_i & ~AW'(ROW-1);
            r_rows  <= AW'(w_span);
            r_fcnt  <= '0;
            r_state <= S_FETCH;
          end else begin
            r_state <= S_DONE;
          end
        end
        // Extra cycle at r_fcnt == ROW lets the last read land in the buffer.
        S_FETCH: begin
          if (r_fcnt == (IW+1)'(ROW)) r_state <= S_NL;
          else                        r_fcnt  <= r_fcnt + 1'b1;
        end
        S_NL: if (w_xfer) begin
          r_idx   <= '0;
          r_state <= S_ADR;
        end
        S_ADR: if (w_xfer) begin
          if (int'(r_idx) == ADIG-1) r_state <= S_COLON;
          else                       r_idx   <= r_idx + 1'b1;
        end
        S_COLON: if (w_xfer) begin
          r_idx   <= '0;
          r_sub   <= 2'd0;
          r_state <= S_HEX;
        end
        // r_sub: 0 = group space, 1 = high nibble, 2 = low nibble.
        S_HEX: if (w_xfer) begin
          if (r_sub == 2'd2) begin
            if (int'(r_idx) == ROW-1) begin
              r_idx   <= '0;
              r_state <= S_SEP;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_sub <= (((int'(r_idx) + 1) % GRP) == 0) ? 2'd0 : 2'd1;
            end
          end else begin
            r_sub <= r_sub + 1'b1;
          end
        end
        S_SEP: if (w_xfer) begin
          if (r_idx == 8'd1) begin
            r_idx   <= '0;
            r_state <= S_ASC;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_ASC: if (w_xfer) begin
          if (int'(r_idx) == ROW-1) begin
            r_base <= r_base + AW'(ROW);
            r_rows <= r_rows - AW'(1);
            r_fcnt <= '0;
            r_state <= (r_rows == AW'(1)) ? S_FIN : S_FETCH;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_FIN:   if (w_xfer) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_rd_v) r_buf[r_rd_idx] <= bus.mem_d_i;
  end

  assign bus.mem_re_o = w_re;
  assign bus.mem_a_o  = r_base | AW'(r_fcnt[IW-1:0]);
  assign bus.busy_o   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done_o   = (r_state == S_DONE);
  assign bus.ch_v_o   = (r_state >= S_NL) && (r_state <= S_FIN);

  always_comb begin
    bus.ch_o = 8'h00;
    case (r_state)
      S_NL:    bus.ch_o = 8'h0a;
      S_ADR:   bus.ch_o = f_hex(w_nib);
      S_COLON: bus.ch_o = 8'h3a;
      S_HEX: begin
        case (r_sub)
          2'd0:    bus.ch_o = 8'h20;
          2'd1:    bus.ch_o = f_hex(w_byte[7:4]);
          default: bus.ch_o = f_hex(w_byte[3:0]);
        endcase
      end
      S_SEP:   bus.ch_o = 8'h20;
      S_ASC:   bus.ch_o = (w_byte < 8'h20 || w_byte > 8'h7e) ? 8'h2e : w_byte;
      S_FIN:   bus.ch_o = 8'h0a;
      default: bus.ch_o = 8'h00;
    endcase
  end
endmodule
